// File: rtl/mem_port_arbiter.sv
// Shares one AXI4-Lite command master between instruction fetch (I) and data (D) requesters.
// One transaction in flight; owner gets done one cycle after m_done, or done+err after TIMEOUT wait cycles.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int FAIR    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              m_start,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                start_ok;
  logic                pick_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                timed_out;

  assign start_ok  = (i_req | d_req) & ~m_busy;
  // Fair mode hands a conflict to whichever requester did not win last time.
  assign pick_d    = d_req & (~i_req | (FAIR == 0) | (last_q == OWN_I));
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (m_done || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : datapath
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          owner_d = pick_d;
          last_d  = pick_d;
          addr_d  = pick_d ? d_addr : i_addr;
          wr_d    = pick_d & d_wr;
          wdata_d = pick_d ? d_wdata : '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A response arriving on the timeout cycle still counts as a success.
        if (m_done) begin
          err_d = 1'b0;
          if (!wr_q && owner_q == OWN_D) d_rdata_d = m_rdata;
          if (!wr_q && owner_q == OWN_I) i_rdata_d = m_rdata;
        end else if (timed_out) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin : outputs
    m_start = (state_q == ISSUE);
    busy    = (state_q != IDLE);
    i_done  = (state_q == RESP) && (owner_q == OWN_I);
    d_done  = (state_q == RESP) && (owner_q == OWN_D);
    i_err   = i_done & err_q;
    d_err   = d_done & err_q;
  end

  assign m_addr  = addr_q;
  assign m_wr    = wr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: dut 0 is fair, dut 1 gives D priority; both time out after 4 wait cycles.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_req[2], d_req[2], d_wr[2];
  logic [AW-1:0] i_addr[2], d_addr[2], m_addr[2];
  logic [DW-1:0] d_wdata[2], i_rdata[2], d_rdata[2], m_wdata[2], m_rdata[2];
  logic          i_done[2], i_err[2], d_done[2], d_err[2];
  logic          m_start[2], m_wr[2], busy[2], m_busy[2], m_done[2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR((k == 0) ? 1 : 0), .TIMEOUT(TMO)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req[k]), .i_addr(i_addr[k]), .i_rdata(i_rdata[k]), .i_done(i_done[k]), .i_err(i_err[k]),
      .d_req(d_req[k]), .d_wr(d_wr[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
      .d_rdata(d_rdata[k]), .d_done(d_done[k]), .d_err(d_err[k]),
      .m_start(m_start[k]), .m_wr(m_wr[k]), .m_addr(m_addr[k]), .m_wdata(m_wdata[k]),
      .m_busy(m_busy[k]), .m_done(m_done[k]), .m_rdata(m_rdata[k]), .busy(busy[k])
    );
  end

  typedef struct { int k; logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; } iss_t;
  typedef struct { int k; logic who; logic err; logic [DW-1:0] ei; logic [DW-1:0] ed; } cmp_t;
  typedef struct {
    logic who; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdv;
    int lat; logic err; logic [DW-1:0] ei; logic [DW-1:0] ed;
  } vec_t;

  iss_t iq[$];
  cmp_t cq[$];
  iss_t ie;
  cmp_t ce;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat[2];
  logic [DW-1:0] model_rdata[2];
  int cd[2], done_cnt[2], start_cyc[2], last_mdone[2];
  logic start_prev[2], busy_prev[2], mbusy_prev[2];
  logic [AW-1:0] cap_addr[2];
  logic          cap_wr[2];
  logic [DW-1:0] cap_wdata[2];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic push_tx(input int k, input logic who, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic err,
                         input logic [DW-1:0] ei, input logic [DW-1:0] ed);
    iq.push_back('{k, addr, wr, wdata});
    cq.push_back('{k, who, err, ei, ed});
  endtask

  task automatic wait_dones(input int k, input int n, input int budget);
    int target;
    int t;
    target = done_cnt[k] + n;
    t = 0;
    while (done_cnt[k] < target && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    check("done_within_budget", done_cnt[k] >= target, 1);
  endtask

  // Master model: m_done 'lat' cycles after m_start, m_busy high from m_start until m_done.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_done[k] = 1'b0; m_rdata[k] = '0; cd[k] = 0;
    end
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        m_done[k] = 1'b0;
        if (cd[k] > 0) begin
          cd[k]--;
          if (cd[k] == 0) begin
            m_done[k] = 1'b1; m_rdata[k] = model_rdata[k]; m_busy[k] = 1'b0;
          end
        end
        if (m_start[k] === 1'b1) begin
          m_busy[k] = 1'b1; cd[k] = lat[k];
        end
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0; start_cyc[k] = 0; last_mdone[k] = 0;
      start_prev[k] = 1'b0; busy_prev[k] = 1'b0; mbusy_prev[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (m_done[k]) last_mdone[k] = cyc;
        if (m_start[k] === 1'b1) begin
          check("start_from_idle_free", {start_prev[k], busy_prev[k], mbusy_prev[k]}, 0);
          if (iq.size() == 0) check("unexpected_start", 1, 0);
          else begin
            ie = iq.pop_front();
            check("start_dut", k, ie.k);
            check("m_addr", m_addr[k], ie.addr);
            check("m_wr", m_wr[k], ie.wr);
            if (ie.wr) check("m_wdata", m_wdata[k], ie.wdata);
          end
          start_cyc[k] = cyc;
          cap_addr[k] = m_addr[k]; cap_wr[k] = m_wr[k]; cap_wdata[k] = m_wdata[k];
        end else if (busy[k] === 1'b1) begin
          check("m_cmd_stable", {m_addr[k], m_wr[k], m_wdata[k]}, {cap_addr[k], cap_wr[k], cap_wdata[k]});
        end
        if (i_done[k] === 1'b1 || d_done[k] === 1'b1) begin
          done_cnt[k]++;
          if (cq.size() == 0) check("unexpected_done", 1, 0);
          else begin
            ce = cq.pop_front();
            check("done_dut", k, ce.k);
            check("done_owner", {d_done[k], i_done[k]}, ce.who ? 2'b10 : 2'b01);
            check("err_bits", {d_err[k], i_err[k]}, ce.err ? (ce.who ? 2'b10 : 2'b01) : 2'b00);
            check("i_rdata", i_rdata[k], ce.ei);
            check("d_rdata", d_rdata[k], ce.ed);
            check("done_latency", cyc, ce.err ? start_cyc[k] + TMO + 1 : last_mdone[k] + 1);
          end
        end
        start_prev[k] = m_start[k]; busy_prev[k] = busy[k]; mbusy_prev[k] = m_busy[k];
      end
    end
  end

  vec_t vt[7];
  int t;

  initial begin
    // who(1=D), wr, addr, wdata, master rdata, latency, err, expected i_rdata, expected d_rdata
    vt[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hB123, 2, 1'b0, 16'hB123, 16'h0000};
    vt[1] = '{1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h9999, 2, 1'b0, 16'hB123, 16'h0000};
    vt[2] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 16'h5A5A, 3, 1'b0, 16'hB123, 16'h5A5A};
    vt[3] = '{1'b1, 1'b1, 16'h0044, 16'h1234, 16'h7777, 1, 1'b0, 16'hB123, 16'h5A5A};
    vt[4] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h4444, 5, 1'b1, 16'hB123, 16'h5A5A};
    vt[5] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0001, 1, 1'b0, 16'h0001, 16'h5A5A};
    vt[6] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hCAFE, 4, 1'b0, 16'hCAFE, 16'h5A5A};

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; d_req[k] = 1'b0; d_wr[k] = 1'b0;
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      lat[k] = 2; model_rdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_ctl", {busy[k], m_start[k], i_done[k], d_done[k], i_err[k], d_err[k], m_wr[k]}, 0);
      check("reset_data", {m_addr[k], m_wdata[k], i_rdata[k], d_rdata[k]}, 0);
    end
    rst = 1'b0;
    @(negedge clk); #1;

    // Single-requester transactions on the fair instance.
    for (int n = 0; n < 7; n++) begin
      lat[0] = vt[n].lat;
      model_rdata[0] = vt[n].rdv;
      push_tx(0, vt[n].who, vt[n].wr, vt[n].addr, vt[n].wdata, vt[n].err, vt[n].ei, vt[n].ed);
      if (vt[n].who) begin
        d_req[0] = 1'b1; d_wr[0] = vt[n].wr; d_addr[0] = vt[n].addr; d_wdata[0] = vt[n].wdata;
      end else begin
        i_req[0] = 1'b1; i_addr[0] = vt[n].addr;
      end
      wait_dones(0, 1, 40);
      i_req[0] = 1'b0; d_req[0] = 1'b0;
      @(negedge clk); #1;
    end

    // Fair conflict: last owner is I, so grants alternate D, I, D, I.
    lat[0] = 2; model_rdata[0] = 16'h1111;
    i_addr[0] = 16'h0300; d_addr[0] = 16'h0400; d_wr[0] = 1'b1; d_wdata[0] = 16'hD00D;
    push_tx(0, 1'b1, 1'b1, 16'h0400, 16'hD00D, 1'b0, 16'hCAFE, 16'h5A5A);
    push_tx(0, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h1111, 16'h5A5A);
    push_tx(0, 1'b1, 1'b1, 16'h0400, 16'hD00D, 1'b0, 16'h1111, 16'h5A5A);
    push_tx(0, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h1111, 16'h5A5A);
    i_req[0] = 1'b1; d_req[0] = 1'b1;
    wait_dones(0, 4, 100);
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    @(negedge clk); #1;

    // D-priority conflict: D wins while it requests; I only after d_req drops.
    lat[1] = 2; model_rdata[1] = 16'h2222;
    i_addr[1] = 16'h0600; d_addr[1] = 16'h0500; d_wr[1] = 1'b0;
    push_tx(1, 1'b1, 1'b0, 16'h0500, 16'h0000, 1'b0, 16'h0000, 16'h2222);
    push_tx(1, 1'b1, 1'b0, 16'h0500, 16'h0000, 1'b0, 16'h0000, 16'h2222);
    push_tx(1, 1'b1, 1'b0, 16'h0500, 16'h0000, 1'b0, 16'h0000, 16'h2222);
    push_tx(1, 1'b0, 1'b0, 16'h0600, 16'h0000, 1'b0, 16'h2222, 16'h2222);
    i_req[1] = 1'b1; d_req[1] = 1'b1;
    wait_dones(1, 3, 80);
    d_req[1] = 1'b0;
    wait_dones(1, 1, 30);
    i_req[1] = 1'b0;
    @(negedge clk); #1;

    // Timeout: master answers late; next issue waits for m_busy to drop.
    lat[0] = 8; model_rdata[0] = 16'h3333;
    d_addr[0] = 16'h0700; d_wr[0] = 1'b0;
    push_tx(0, 1'b1, 1'b0, 16'h0700, 16'h0000, 1'b1, 16'h1111, 16'h5A5A);
    push_tx(0, 1'b1, 1'b0, 16'h0700, 16'h0000, 1'b0, 16'h1111, 16'h3333);
    d_req[0] = 1'b1;
    wait_dones(0, 1, 40);
    lat[0] = 2;
    wait_dones(0, 1, 40);
    d_req[0] = 1'b0;
    @(negedge clk); #1;

    // Reset while waiting on the master.
    lat[0] = 8; model_rdata[0] = 16'h4444;
    d_addr[0] = 16'h0800; d_wr[0] = 1'b0;
    iq.push_back('{0, 16'h0800, 1'b0, 16'h0000});
    d_req[0] = 1'b1;
    t = 0;
    while (m_start[0] !== 1'b1 && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    check("rst_seq_start_seen", m_start[0], 1);
    @(negedge clk); #1;
    rst = 1'b1; d_req[0] = 1'b0;
    @(negedge clk); #1;
    check("rst_wait_ctl", {busy[0], m_start[0], i_done[0], d_done[0], i_err[0], d_err[0], m_wr[0]}, 0);
    check("rst_wait_data", {m_addr[0], m_wdata[0], i_rdata[0], d_rdata[0]}, 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #1;

    check("issue_queue_empty", iq.size(), 0);
    check("done_queue_empty", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
